// File: rtl/gpr_writeback_queue.sv
// In-order writeback queue between the ALU/LSU result buses and the GPR write port.
// Round-robin accepts at most one beat per cycle; the queue drains one rd write per cycle.
module gpr_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        alu_valid_in,
   input  logic [4:0]  alu_rd_addr_in,
   input  logic [31:0] alu_data_in,
   output logic        alu_ready_out,
   input  logic        lsu_valid_in,
   input  logic [4:0]  lsu_rd_addr_in,
   input  logic [31:0] lsu_data_in,
   output logic        lsu_ready_out,
   input  logic        wb_hold_in,
   input  logic        flush_in,
   output logic        rd_we_out,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] rd_data_out,
   output logic [31:0] pending_mask_out
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          prio_lsu;

   logic          grant_alu;
   logic          grant_lsu;
   logic          tie;
   logic          can_accept;
   logic          accept;
   logic          push;
   logic          pop;
   logic [4:0]    in_addr;
   logic [31:0]   in_data;

   always_comb begin
      tie        = alu_valid_in & lsu_valid_in;
      grant_alu  = alu_valid_in & (~lsu_valid_in | ~prio_lsu);
      grant_lsu  = lsu_valid_in & (~alu_valid_in | prio_lsu);
      // Full blocks acceptance even when a pop happens on the same edge.
      can_accept = ~reset_in & ~flush_in & (count < CW'(DEPTH));
      alu_ready_out = grant_alu & can_accept;
      lsu_ready_out = grant_lsu & can_accept;
      accept     = alu_ready_out | lsu_ready_out;
      in_addr    = grant_lsu ? lsu_rd_addr_in : alu_rd_addr_in;
      in_data    = grant_lsu ? lsu_data_in : alu_data_in;
      // x0 beats handshake normally but are dropped here.
      push       = accept & (in_addr != 5'd0);
      pop        = ~flush_in & ~wb_hold_in & (count != '0);
   end

   always_ff @(posedge clock_in) begin
      if (push) begin
         addr_q[wr_ptr] <= in_addr;
         data_q[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         prio_lsu    <= 1'b0;
         rd_we_out   <= 1'b0;
         rd_addr_out <= '0;
         rd_data_out <= '0;
      end else begin
         if (flush_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_we_out <= 1'b0;
         end else begin
            if (pop) begin
               rd_we_out   <= 1'b1;
               rd_addr_out <= addr_q[rd_ptr];
               rd_data_out <= data_q[rd_ptr];
               rd_ptr      <= rd_ptr + 1'b1;
            end else begin
               rd_we_out <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         if (tie & accept) prio_lsu <= ~prio_lsu;
      end
   end

   // Entry i is live when its distance from the head is below count.
   always_comb begin
      logic [AW-1:0] off;
      pending_mask_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rd_ptr;
         if ({1'b0, off} < count) pending_mask_out[addr_q[i]] = 1'b1;
      end
      if (rd_we_out) pending_mask_out[rd_addr_out] = 1'b1;
      pending_mask_out[0] = 1'b0;
   end

endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Bench for gpr_writeback_queue: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_gpr_writeback_queue;

   localparam int DEPTH = 4;

   logic        clock_in = 1'b0;
   logic        reset_in = 1'b1;
   logic        alu_valid_in = 1'b0;
   logic [4:0]  alu_rd_addr_in = '0;
   logic [31:0] alu_data_in = '0;
   logic        alu_ready_out;
   logic        lsu_valid_in = 1'b0;
   logic [4:0]  lsu_rd_addr_in = '0;
   logic [31:0] lsu_data_in = '0;
   logic        lsu_ready_out;
   logic        wb_hold_in = 1'b0;
   logic        flush_in = 1'b0;
   logic        rd_we_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] rd_data_out;
   logic [31:0] pending_mask_out;

   gpr_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clock_in(clock_in), .reset_in(reset_in),
      .alu_valid_in(alu_valid_in), .alu_rd_addr_in(alu_rd_addr_in), .alu_data_in(alu_data_in),
      .alu_ready_out(alu_ready_out),
      .lsu_valid_in(lsu_valid_in), .lsu_rd_addr_in(lsu_rd_addr_in), .lsu_data_in(lsu_data_in),
      .lsu_ready_out(lsu_ready_out),
      .wb_hold_in(wb_hold_in), .flush_in(flush_in),
      .rd_we_out(rd_we_out), .rd_addr_out(rd_addr_out), .rd_data_out(rd_data_out),
      .pending_mask_out(pending_mask_out)
   );

   always #5 clock_in = ~clock_in;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   bit          m_prio_lsu;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        exp_ar;
   logic        exp_lr;

   task automatic model_reset();
      mq.delete();
      m_prio_lsu = 0;
      m_we = 0;
      m_addr = '0;
      m_data = '0;
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m = '0;
      foreach (mq[i]) m[mq[i].a] = 1'b1;
      if (m_we) m[m_addr] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   // One clock: drive inputs, check handshake, clock it, check registered outputs.
   task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic hold, input logic flush);
      logic room;
      logic acc;
      logic [4:0] a;
      logic [31:0] d;
      alu_valid_in = av; alu_rd_addr_in = aa; alu_data_in = ad;
      lsu_valid_in = lv; lsu_rd_addr_in = la; lsu_data_in = ld;
      wb_hold_in = hold; flush_in = flush;
      #1;
      room = (mq.size() < DEPTH) && !flush;
      if (av && lv) begin
         exp_ar = room && !m_prio_lsu;
         exp_lr = room && m_prio_lsu;
      end else begin
         exp_ar = room && av;
         exp_lr = room && lv;
      end
      check("alu_ready", {31'd0, alu_ready_out}, {31'd0, exp_ar});
      check("lsu_ready", {31'd0, lsu_ready_out}, {31'd0, exp_lr});
      check("mask_pre", pending_mask_out, model_mask());
      @(posedge clock_in);
      acc = exp_ar | exp_lr;
      a = exp_lr ? la : aa;
      d = exp_lr ? ld : ad;
      if (flush) begin
         mq.delete();
         m_we = 0;
      end else if (!hold && mq.size() > 0) begin
         m_we = 1;
         m_addr = mq[0].a;
         m_data = mq[0].d;
         void'(mq.pop_front());
      end else begin
         m_we = 0;
      end
      if (acc && a != 5'd0) mq.push_back('{a: a, d: d});
      if (acc && av && lv) m_prio_lsu = !m_prio_lsu;
      #1;
      check("rd_we", {31'd0, rd_we_out}, {31'd0, m_we});
      check("rd_addr", {27'd0, rd_addr_out}, {27'd0, m_addr});
      check("rd_data", rd_data_out, m_data);
      check("mask_post", pending_mask_out, model_mask());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset_in = 1'b1;
      #3;
      model_reset();
      check("rst_we", {31'd0, rd_we_out}, 32'd0);
      check("rst_mask", pending_mask_out, 32'd0);
      @(negedge clock_in);
      reset_in = 1'b0;
   endtask

   logic        a_v, l_v;
   logic [4:0]  a_a, l_a;
   logic [31:0] a_d, l_d;
   int          tries;

   initial begin
      model_reset();
      alu_valid_in = 1'b1;
      lsu_valid_in = 1'b1;
      #12;
      check("rst_alu_ready", {31'd0, alu_ready_out}, 32'd0);
      check("rst_lsu_ready", {31'd0, lsu_ready_out}, 32'd0);
      check("rst_we0", {31'd0, rd_we_out}, 32'd0);
      check("rst_addr", {27'd0, rd_addr_out}, 32'd0);
      check("rst_data", rd_data_out, 32'd0);
      check("rst_mask0", pending_mask_out, 32'd0);
      @(negedge clock_in);
      reset_in = 1'b0;

      // Single ALU beat: latency and pending-mask lifetime.
      step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      check("t1_mask_e1", pending_mask_out, 32'h20);
      check("t1_we_e1", {31'd0, rd_we_out}, 32'd0);
      idle(1);
      check("t1_we_e2", {31'd0, rd_we_out}, 32'd1);
      check("t1_data_e2", rd_data_out, 32'hDEADBEEF);
      check("t1_mask_e2", pending_mask_out, 32'h20);
      idle(1);
      check("t1_mask_e3", pending_mask_out, 32'd0);

      // Tie straight out of reset: ALU first, then LSU.
      do_reset();
      step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0);
      step(0, 0, 0, 1, 5'd2, 32'h22, 0, 0);
      check("t2_first", {27'd0, rd_addr_out}, 32'd1);
      idle(1);
      check("t2_second", {27'd0, rd_addr_out}, 32'd2);
      check("t2_data", rd_data_out, 32'h22);
      idle(2);

      // x0 write is accepted and dropped.
      step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
      idle(3);
      check("t3_mask", pending_mask_out, 32'd0);

      // Fill under hold, then drain.
      for (int k = 1; k <= 5; k++) step(1, 5'(k), 32'h100 + k, 0, 0, 0, 1, 0);
      check("t4_mask", pending_mask_out, 32'h1E);
      tries = 0;
      do begin
         step(1, 5'd5, 32'h105, 0, 0, 0, 0, 0);
         tries++;
      end while (!exp_ar && tries < 10);
      check("t4_accept_bound", {31'd0, exp_ar}, 32'd1);
      idle(6);

      // Flush with hold on a three-entry queue.
      for (int k = 0; k < 3; k++) step(1, 5'(k + 9), 32'h200 + k, 0, 0, 0, 1, 0);
      step(1, 5'd20, 32'h300, 1, 5'd21, 32'h301, 1, 1);
      check("t5_mask", pending_mask_out, 32'd0);
      idle(2);

      // Asynchronous reset while a write is on the port.
      step(1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("t6_we_before", {31'd0, rd_we_out}, 32'd1);
      alu_valid_in = 1'b1;
      lsu_valid_in = 1'b1;
      #2;
      reset_in = 1'b1;
      #1;
      check("t6_we_async", {31'd0, rd_we_out}, 32'd0);
      check("t6_mask_async", pending_mask_out, 32'd0);
      check("t6_addr_async", {27'd0, rd_addr_out}, 32'd0);
      check("t6_ready_async", {30'd0, alu_ready_out, lsu_ready_out}, 32'd0);
      model_reset();
      @(negedge clock_in);
      reset_in = 1'b0;
      step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0);
      check("t6_alu_first", {31'd0, exp_ar}, 32'd1);
      idle(3);

      // Random traffic; sources hold a beat until it is accepted.
      a_v = 0; l_v = 0; a_a = 0; l_a = 0; a_d = 0; l_d = 0;
      for (int c = 0; c < 600; c++) begin
         if (!a_v && $urandom_range(0, 9) < 6) begin
            a_v = 1;
            a_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a_d = $urandom;
         end
         if (!l_v && $urandom_range(0, 9) < 5) begin
            l_v = 1;
            l_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            l_d = $urandom;
         end
         step(a_v, a_a, a_d, l_v, l_a, l_d,
              $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
         if (exp_ar) a_v = 0;
         if (exp_lr) l_v = 0;
      end
      idle(6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
